alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one integer ALU between two requesters: the execute stage (requester 0) and the address/branch helper (requester 1). A round-robin arbiter grants one valid request per cycle. The ALU result is computed combinationally and captured in a 2-entry result FIFO. Results are returned through a valid/ready response port tagged with the source requester.

## Interface

Parameters:
- WIDTH, 32, operand and result width; shift amount is always operand bits [4:0].
- DEPTH, 2, result FIFO entries; only 2 is supported and verified.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_rs1, req0_rs2  in  WIDTH  requester 0 operands.
- req0_op  in  4  requester 0 ALU op; shared-package ALU_* encoding.
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_op: same as requester 0, for requester 1.
- resp_valid  out  1  FIFO head holds a result.
- resp_ready  in  1  consumer takes the head this cycle.
- resp_rd  out  WIDTH  result at the FIFO head.
- resp_src  out  1  requester that issued the head result.

## Operation

- Accept condition: `can_push = (count < 2) || (resp_valid && resp_ready)`.
- Arbitration, evaluated combinationally each cycle:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester that is not `last_grant`.
- `reqN_ready = can_push && grant == N`.
  - ready depends on valid. Requesters must not make valid depend on ready.
- A transfer occurs when `reqN_valid && reqN_ready`. On transfer:
  - The muxed operands and op drive the single ALU instance.
  - `{rd, src}` is written at the write pointer.
  - `last_grant <= N`.
- `last_grant` is unchanged on cycles with no transfer. A stalled requester keeps its priority.
- Pop occurs when `resp_valid && resp_ready`; the read pointer advances.
- Push and pop in the same cycle:
  - Allowed at any count, including count==2 (full).
  - count is unchanged.
  - The pushed entry never bypasses to the output in the same cycle.
- Pointers are 1 bit and wrap 1→0. count is 2 bits, range 0..2. It never exceeds 2 and never underflows; both are assertion-checked.
- Unknown op: the ALU returns 0, which is stored and returned normally. No error signal.
- Arithmetic is WIDTH-bit, modulo 2^WIDTH, with no carry or overflow outputs.
  - SLT is a signed compare; SLTU is unsigned.
  - Shifts use rs2[4:0] only.

## Timing

- Reset values:
  - resp_valid=0; resp_rd=0 (head entry cleared); resp_src=0.
  - count=0; pointers=0; `last_grant=1`, so requester 0 wins the first tie.
- reqN_ready is combinational. With no valid request, both readies are 0.
- Latency: a transfer in cycle T gives resp_valid=1 in cycle T+1, if the FIFO was empty.
- Throughput: 1 result/cycle sustained with resp_ready held at 1.
- Full FIFO and resp_ready=0: both readies are 0 and requests stall. No result is ever dropped or reordered.
- rst asserted mid-operation:
  - At the next edge, all FIFO contents are discarded and all reset values apply.
  - Requests presented while rst=1 are not accepted; readies are forced to 0.

## Structure

- Shared package `datatypes.sv` holds:
  - The ALU_* op encodings, reused unchanged.
  - A new `alu_resp_t` packed struct {rd, src}.
- Sub-module: one instance of the existing `alu`.
- FIFO and arbiter are coded inline; no further sub-modules.
- Assertions:
  - count ≤ 2.
  - At most one reqN_ready high.
  - No push when !can_push.

## Test plan

- Reset: hold rst 2 cycles with both valids high → req0_ready=req1_ready=0, resp_valid=0. The first tie after release grants requester 0.
- Single op: req0 ADD rs1=5, rs2=7, resp_ready=1 → req0_ready=1 in cycle T; cycle T+1 resp_valid=1, resp_rd=12, resp_src=0.
- Operation checks:
  - req1 SUB 3−5 → resp_rd=0xFFFFFFFE, src=1.
  - SLT −1<1 → 1.
  - SLTU 0xFFFFFFFF<1 → 0.
- Fairness: both requesters valid continuously with resp_ready=1 → grants alternate 0,1,0,1 for 8 cycles; resp_src sequence matches.
- Backpressure: resp_ready=0 with both streaming:
  - Two transfers occur (src 0 then 1), then both readies drop to 0 and count=2.
  - A single-cycle resp_ready=1 pops src 0 and pushes requester 0's next op in the same cycle; count stays 2.
- Reset mid-operation: assert rst with FIFO full → next cycle resp_valid=0 and count=0. After release, a tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings and the result-FIFO entry type used by the
// ALU arbiter and its ALU instance.
package alu_arbiter_pkg;

    localparam int RESP_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [RESP_W-1:0] rd;
        logic              src;
    } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU; unknown ops return zero.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [4:0]              shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = a_s >>> shamt;
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with results
// buffered in a 2-entry FIFO and returned tagged with their source.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [3:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rd,
    output logic             resp_src
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    alu_resp_t        fifo [0:1];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             last_grant;

    logic             grant;
    logic             pop;
    logic             push;
    logic             can_push;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign resp_valid = (count != 2'd0);
    assign pop        = resp_valid && resp_ready;
    assign can_push   = !rst && ((count < FULL) || pop);
    assign req0_ready = can_push && req0_valid && !grant;
    assign req1_ready = can_push && req1_valid && grant;
    assign push       = req0_ready || req1_ready;

    assign alu_op = grant ? req1_op  : req0_op;
    assign alu_a  = grant ? req1_rs1 : req0_rs1;
    assign alu_b  = grant ? req1_rs2 : req0_rs2;

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op(alu_op),
        .a (alu_a),
        .b (alu_b),
        .y (alu_y)
    );

    assign resp_rd  = fifo[rd_ptr].rd;
    assign resp_src = fifo[rd_ptr].src;

    // A push at full only happens alongside a pop, so it overwrites the head
    // being consumed this cycle; the output always comes from registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            last_grant <= 1'b1;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{rd: alu_y, src: grant};
                wr_ptr       <= ~wr_ptr;
                last_grant   <= grant;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= FULL);
            assert (!(req0_ready && req1_ready));
            assert (!push || can_push);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [3:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_src;
    logic [31:0] resp_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_src(resp_src)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return sa >>> b[4:0];
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // Reference model: queue of {rd, src} and the last winner.
    logic [32:0] q[$];
    logic        lg = 1'b1;
    bit          chk_en = 1'b0;
    logic        m_can, m_g, m_e0, m_e1;
    logic [32:0] m_head;

    always @(negedge clk) begin
        m_can = (q.size() < 2) || (q.size() != 0 && resp_ready);
        m_g   = (req0_valid && req1_valid) ? !lg : req1_valid;
        m_e0  = !rst && m_can && req0_valid && !m_g;
        m_e1  = !rst && m_can && req1_valid && m_g;
        if (chk_en) begin
            check("req0_ready", 32'(req0_ready), 32'(m_e0));
            check("req1_ready", 32'(req1_ready), 32'(m_e1));
            check("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
            check("count", 32'(dut.count), 32'(q.size()));
            if (q.size() != 0) begin
                m_head = q[0];
                check("resp_rd", resp_rd, m_head[32:1]);
                check("resp_src", 32'(resp_src), 32'(m_head[0]));
            end
        end
        if (rst) begin
            q.delete();
            lg = 1'b1;
        end else begin
            if (q.size() != 0 && resp_ready) void'(q.pop_front());
            if (m_e0 || m_e1) begin
                q.push_back(m_g ? {model_alu(req1_op, req1_rs1, req1_rs2), 1'b1}
                                : {model_alu(req0_op, req0_rs1, req0_rs2), 1'b0});
                lg = m_g;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b;
    endtask

    logic [3:0] ops0 [0:7];
    logic [3:0] ops1 [0:7];

    initial begin
        ops0 = '{ALU_ADD, ALU_SLL, ALU_SRA, ALU_AND, ALU_OR, ALU_SRL, ALU_SLT, ALU_SUB};
        ops1 = '{ALU_XOR, ALU_SUB, 4'hF, ALU_SLTU, ALU_ADD, ALU_SRA, ALU_OR, ALU_SLL};

        rst = 1'b1;
        resp_ready = 1'b0;
        drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
        drive1(1'b1, ALU_SUB, 32'd3, 32'd5);

        // Reset held two cycles with both requesters valid.
        @(posedge clk);
        chk_en = 1'b1;
        #1; settle();
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rd", resp_rd, 32'd0);
        check("rst_resp_src", 32'(resp_src), 32'd0);
        step(); settle();
        check("rst2_req0_ready", 32'(req0_ready), 32'd0);
        check("rst2_req1_ready", 32'(req1_ready), 32'd0);

        // First tie after release goes to requester 0 (ADD 5+7).
        step();
        rst = 1'b0;
        resp_ready = 1'b1;
        settle();
        check("tie_req0_ready", 32'(req0_ready), 32'd1);
        check("tie_req1_ready", 32'(req1_ready), 32'd0);

        step();
        req0_valid = 1'b0;
        settle();
        check("add_valid", 32'(resp_valid), 32'd1);
        check("add_rd", resp_rd, 32'd12);
        check("add_src", 32'(resp_src), 32'd0);
        check("sub_req1_ready", 32'(req1_ready), 32'd1);

        step();
        req1_valid = 1'b0;
        drive0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        settle();
        check("sub_rd", resp_rd, 32'hFFFF_FFFE);
        check("sub_src", 32'(resp_src), 32'd1);

        step();
        drive0(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        settle();
        check("slt_rd", resp_rd, 32'd1);
        check("slt_src", 32'(resp_src), 32'd0);

        step();
        req0_valid = 1'b0;
        settle();
        check("sltu_valid", 32'(resp_valid), 32'd1);
        check("sltu_rd", resp_rd, 32'd0);

        step(); settle();
        check("drained_valid", 32'(resp_valid), 32'd0);

        // Fairness: requester 0 won last, so requester 1 leads the alternation.
        for (int i = 0; i < 8; i++) begin
            step();
            drive0(1'b1, ops0[i], 32'(i + 1) * 32'h0101_0101, 32'(i * 3));
            drive1(1'b1, ops1[i], 32'hF000_0000 - 32'(i), 32'(i + 2));
            settle();
            check("fair_req1_ready", 32'(req1_ready), 32'(i % 2 == 0));
            check("fair_req0_ready", 32'(req0_ready), 32'(i % 2 == 1));
        end

        step();
        req0_valid = 1'b0;
        drive1(1'b1, ALU_ADD, 32'd1, 32'd1);
        settle();
        check("solo_req1_ready", 32'(req1_ready), 32'd1);

        step();
        req1_valid = 1'b0;
        step(); settle();
        check("drain2_valid", 32'(resp_valid), 32'd0);

        // Backpressure: two transfers then stall with a full FIFO.
        step();
        resp_ready = 1'b0;
        drive0(1'b1, ALU_ADD, 32'd10, 32'd1);
        drive1(1'b1, ALU_ADD, 32'd20, 32'd1);
        settle();
        check("bp0_req0_ready", 32'(req0_ready), 32'd1);

        step();
        drive0(1'b1, ALU_ADD, 32'd11, 32'd1);
        settle();
        check("bp1_req1_ready", 32'(req1_ready), 32'd1);
        check("bp1_req0_ready", 32'(req0_ready), 32'd0);

        step(); settle();
        check("bp2_req0_ready", 32'(req0_ready), 32'd0);
        check("bp2_req1_ready", 32'(req1_ready), 32'd0);
        check("bp2_count", 32'(dut.count), 32'd2);
        check("bp2_src", 32'(resp_src), 32'd0);
        check("bp2_rd", resp_rd, 32'd11);

        step();
        resp_ready = 1'b1;
        settle();
        check("bp3_req0_ready", 32'(req0_ready), 32'd1);
        check("bp3_src", 32'(resp_src), 32'd0);

        step();
        resp_ready = 1'b0;
        settle();
        check("bp4_count", 32'(dut.count), 32'd2);
        check("bp4_src", 32'(resp_src), 32'd1);
        check("bp4_rd", resp_rd, 32'd21);
        check("bp4_req0_ready", 32'(req0_ready), 32'd0);

        // Reset with the FIFO full.
        step();
        rst = 1'b1;
        settle();
        check("mrst_req0_ready", 32'(req0_ready), 32'd0);
        check("mrst_req1_ready", 32'(req1_ready), 32'd0);

        step();
        rst = 1'b0;
        settle();
        check("mrst_resp_valid", 32'(resp_valid), 32'd0);
        check("mrst_count", 32'(dut.count), 32'd0);
        check("mrst_tie_req0", 32'(req0_ready), 32'd1);
        check("mrst_tie_req1", 32'(req1_ready), 32'd0);

        step();
        resp_ready = 1'b1;
        step();
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
        step();
        step();
        step(); settle();
        check("final_valid", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
